// File: rtl/eth_rx_streamer_pkg.sv
// eth_rx_streamer_pkg
//   Shared definitions for the ethernet_controller register-port clients:
//   FSM state encoding of the RX streamer, controller register addresses,
//   register access size encodings and the last-word byte-keep helper.
package eth_rx_streamer_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT,
    ST_SIZE_REQ,
    ST_SIZE_RSP,
    ST_WORD_REQ,
    ST_WORD_RSP,
    ST_SEND,
    ST_CLEAR
  } rx_state_e;

  // Controller register map (byte addresses)
  localparam logic [15:0] REG_RX_INT_EN  = 16'h1014;
  localparam logic [15:0] REG_RX_PENDING = 16'h1010;
  localparam logic [15:0] REG_RX_SIZE    = 16'h1004;
  localparam logic [15:0] REG_RX_BUF     = 16'h0000;

  // Register port access sizes
  localparam logic [1:0] OP_SIZE_1B = 2'b00;
  localparam logic [1:0] OP_SIZE_2B = 2'b01;
  localparam logic [1:0] OP_SIZE_4B = 2'b10;

  // Byte-keep of the final word of a frame, from the two size LSBs.
  function automatic logic [3:0] last_keep(input logic [1:0] size_lsbs);
    if (size_lsbs == 2'd0) last_keep = 4'hF;
    else                   last_keep = 4'((5'd1 << size_lsbs) - 5'd1);
  endfunction

endpackage

// File: rtl/eth_rx_stream_buf.sv
// eth_rx_stream_buf
//   Single-entry output holding register for the RX word stream. A load
//   captures data/keep/last and raises valid; valid drops after the
//   valid & ready handshake. Contents stay stable while valid and not ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load                       capture word/word_keep/word_last
//   word, word_keep, word_last incoming beat
//   data, keep, last, valid    registered stream outputs
//   ready                      downstream ready
//   fire                       handshake this cycle (valid & ready)
module eth_rx_stream_buf #(
  parameter int data_width_p = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [data_width_p-1:0]   word,
  input  logic [data_width_p/8-1:0] word_keep,
  input  logic                      word_last,
  output logic [data_width_p-1:0]   data,
  output logic [data_width_p/8-1:0] keep,
  output logic                      last,
  output logic                      valid,
  input  logic                      ready,
  output logic                      fire
);

  assign fire = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= word;
      keep  <= word_keep;
      last  <= word_last;
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_streamer.sv
// eth_rx_streamer
//   Drains received frames from an ethernet_controller over its register
//   port and presents them as a valid/ready word stream with keep and last.
//   Register strobes are registered: a strobe is raised on the clock edge
//   that enters the REQ/CLEAR state and is visible during that state.
// Ports:
//   clk_i, reset_n_i               clock, asynchronous active-low reset
//   addr_o, write_en_o, read_en_o, op_size_o, write_data_o, read_data_i
//                                  controller register port (read data valid
//                                  the cycle after read_en_o)
//   rx_interrupt_pending_i         controller RX pending interrupt
//   m_data_o, m_keep_o, m_last_o, m_valid_o, m_ready_i
//                                  output word stream, byte 0 in [7:0]
//   err_o                          one-cycle pulse: oversize frame dropped
//   pkt_count_o                    frames emitted (wraps)
// Build option:
//   ETH_RX_STREAMER_POLL_EN        poll the RX pending register instead of
//                                  waiting on rx_interrupt_pending_i
module eth_rx_streamer
  import eth_rx_streamer_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int buf_size_p       = 2048,
  parameter int reg_addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  output logic [reg_addr_width_p-1:0] addr_o,
  output logic                        write_en_o,
  output logic                        read_en_o,
  output logic [1:0]                  op_size_o,
  output logic [data_width_p-1:0]     write_data_o,
  input  logic [data_width_p-1:0]     read_data_i,
  input  logic                        rx_interrupt_pending_i,
  output logic [data_width_p-1:0]     m_data_o,
  output logic [data_width_p/8-1:0]   m_keep_o,
  output logic                        m_last_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        err_o,
  output logic [15:0]                 pkt_count_o
);

  localparam int packet_size_width_lp = $clog2(buf_size_p) + 1;
  localparam int keep_width_lp        = data_width_p / 8;

  localparam logic [reg_addr_width_p-1:0] ADDR_INT_EN  = reg_addr_width_p'(REG_RX_INT_EN);
  localparam logic [reg_addr_width_p-1:0] ADDR_PENDING = reg_addr_width_p'(REG_RX_PENDING);
  localparam logic [reg_addr_width_p-1:0] ADDR_SIZE    = reg_addr_width_p'(REG_RX_SIZE);
  localparam logic [reg_addr_width_p-1:0] ADDR_BUF     = reg_addr_width_p'(REG_RX_BUF);

  rx_state_e                       state;
  logic [packet_size_width_lp-1:0] size_in;
  logic [packet_size_width_lp-1:0] word_idx;
  logic [packet_size_width_lp-1:0] next_idx;
  logic [packet_size_width_lp-1:0] last_idx;
  logic [1:0]                      size_lsbs;
  logic                            oversize;
  logic                            is_last;
  logic                            load;
  logic                            fire;
  logic [keep_width_lp-1:0]        keep_word;
`ifdef ETH_RX_STREAMER_POLL_EN
  logic [1:0]                      poll_phase;  // 0 issue, 1 strobe, 2 capture
`endif

  assign size_in   = read_data_i[packet_size_width_lp-1:0];
  // Full-width compare so values beyond the captured width are still caught.
  assign oversize  = (read_data_i > data_width_p'(buf_size_p));
  assign next_idx  = word_idx + packet_size_width_lp'(1);
  assign is_last   = (word_idx == last_idx);
  assign load      = (state == ST_WORD_RSP);
  assign keep_word = is_last ? last_keep(size_lsbs) : '1;

  eth_rx_stream_buf #(
    .data_width_p(data_width_p)
  ) u_stream_buf (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .load      (load),
    .word      (read_data_i),
    .word_keep (keep_word),
    .word_last (is_last),
    .data      (m_data_o),
    .keep      (m_keep_o),
    .last      (m_last_o),
    .valid     (m_valid_o),
    .ready     (m_ready_i),
    .fire      (fire)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_INIT;
      addr_o       <= '0;
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
      op_size_o    <= '0;
      write_data_o <= '0;
      err_o        <= 1'b0;
      pkt_count_o  <= '0;
      size_lsbs    <= '0;
      word_idx     <= '0;
      last_idx     <= '0;
`ifdef ETH_RX_STREAMER_POLL_EN
      poll_phase   <= '0;
`endif
    end else begin
      write_en_o <= 1'b0;
      read_en_o  <= 1'b0;
      err_o      <= 1'b0;
      op_size_o  <= OP_SIZE_4B;
      case (state)
        ST_INIT: begin
          write_en_o   <= 1'b1;
          addr_o       <= ADDR_INT_EN;
          write_data_o <= data_width_p'(1);
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
`ifdef ETH_RX_STREAMER_POLL_EN
          // Strobe/capture alternate; the capture edge may relaunch the poll.
          case (poll_phase)
            2'd0: begin
              read_en_o  <= 1'b1;
              addr_o     <= ADDR_PENDING;
              poll_phase <= 2'd1;
            end
            2'd1: poll_phase <= 2'd2;
            default: begin
              read_en_o <= 1'b1;
              if (read_data_i[0]) begin
                addr_o     <= ADDR_SIZE;
                poll_phase <= 2'd0;
                state      <= ST_SIZE_REQ;
              end else begin
                addr_o     <= ADDR_PENDING;
                poll_phase <= 2'd1;
              end
            end
          endcase
`else
          if (rx_interrupt_pending_i) begin
            read_en_o <= 1'b1;
            addr_o    <= ADDR_SIZE;
            state     <= ST_SIZE_REQ;
          end
`endif
        end
        ST_SIZE_REQ: state <= ST_SIZE_RSP;
        ST_SIZE_RSP: begin
          if ((read_data_i == '0) || oversize) begin
            err_o        <= oversize;
            write_en_o   <= 1'b1;
            addr_o       <= ADDR_PENDING;
            write_data_o <= data_width_p'(1);
            state        <= ST_CLEAR;
          end else begin
            size_lsbs <= size_in[1:0];
            // ceil(size/4) - 1, size known non-zero here
            last_idx  <= (size_in - packet_size_width_lp'(1)) >> 2;
            word_idx  <= '0;
            read_en_o <= 1'b1;
            addr_o    <= ADDR_BUF;
            state     <= ST_WORD_REQ;
          end
        end
        ST_WORD_REQ: state <= ST_WORD_RSP;
        ST_WORD_RSP: state <= ST_SEND;
        ST_SEND: begin
          if (fire) begin
            if (is_last) begin
              pkt_count_o  <= pkt_count_o + 16'd1;
              write_en_o   <= 1'b1;
              addr_o       <= ADDR_PENDING;
              write_data_o <= data_width_p'(1);
              state        <= ST_CLEAR;
            end else begin
              word_idx  <= next_idx;
              read_en_o <= 1'b1;
              addr_o    <= ADDR_BUF + reg_addr_width_p'({next_idx, 2'b00});
              state     <= ST_WORD_REQ;
            end
          end
        end
        ST_CLEAR: state <= ST_WAIT;
        default:  state <= ST_INIT;
      endcase
    end
  end

endmodule
